// File: rtl/tis_pkg.sv
// Shared opcode, next-address select and sequencer state encodings for the TIS-100 node.
package tis_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_MOV  = 5'd1;
    localparam logic [4:0] OP_SWP  = 5'd2;
    localparam logic [4:0] OP_SAV  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_NEG  = 5'd6;
    localparam logic [4:0] OP_JMP  = 5'd7;
    localparam logic [4:0] OP_JEZ  = 5'd8;
    localparam logic [4:0] OP_JNZ  = 5'd9;
    localparam logic [4:0] OP_JGZ  = 5'd10;
    localparam logic [4:0] OP_JLZ  = 5'd11;
    localparam logic [4:0] OP_JRO  = 5'd12;
    localparam logic [4:0] OP_HCF  = 5'd13;
    // MOV whose non-port destination is NIL rather than ACC.
    localparam logic [4:0] OP_MOVN = 5'd14;

    localparam logic [1:0] JC_INC   = 2'b00;
    localparam logic [1:0] JC_LABEL = 2'b01;
    localparam logic [1:0] JC_REL   = 2'b10;
    localparam logic [1:0] JC_ZERO  = 2'b11;

    localparam logic [1:0] ST_HALTED  = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_WR_WAIT = 2'd3;

endpackage

// File: rtl/tis_jmp_decode.sv
// Combinational jump decode: opcode plus ACC flags to next-address select.
module tis_jmp_decode
    import tis_pkg::*;
(
    input  logic [0:4] instr_type,
    input  logic       acc_zero,
    input  logic       acc_neg,
    output logic [0:1] jmp_cond,
    output logic       jmp_instr
);

    always_comb begin
        jmp_cond  = JC_INC;
        jmp_instr = 1'b1;
        case (instr_type)
            OP_JMP:  jmp_cond = JC_LABEL;
            OP_JEZ:  jmp_cond = acc_zero ? JC_LABEL : JC_INC;
            OP_JNZ:  jmp_cond = !acc_zero ? JC_LABEL : JC_INC;
            OP_JGZ:  jmp_cond = (!acc_zero && !acc_neg) ? JC_LABEL : JC_INC;
            OP_JLZ:  jmp_cond = acc_neg ? JC_LABEL : JC_INC;
            OP_JRO:  jmp_cond = JC_REL;
            default: jmp_instr = 1'b0;
        endcase
    end

endmodule

// File: rtl/tis_node_seq.sv
// TIS-100 node sequencer: IP advance/select, blocking MOV port handshakes, halt/restart.
module tis_node_seq
    import tis_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hcf,
    input  logic [0:4]         instr_type,
    input  logic               src_is_port,
    input  logic               dst_is_port,
    input  logic               acc_zero,
    input  logic               acc_neg,
    input  logic               rd_ack,
    input  logic               wr_ack,
    output logic               adv,
    output logic [0:1]         jmp_cond,
    output logic               jmp_instr,
    output logic               rd_req,
    output logic               wr_req,
    output logic               acc_we,
    output logic               bak_we,
    output logic               halted,
    output logic [STALL_W-1:0] stall_cycles
);

    logic [1:0]         r_state;
    logic [1:0]         w_nxt;
    logic               r_rd_req;
    logic               r_wr_req;
    logic [STALL_W-1:0] r_stall;
    logic [0:1]         w_dec_cond;
    logic               w_dec_jmp;
    logic               w_halt;
    logic               w_is_mov;
    logic               w_acc_dst;
    logic               w_alu_acc;

    tis_jmp_decode u_jmp_decode (
        .instr_type (instr_type),
        .acc_zero   (acc_zero),
        .acc_neg    (acc_neg),
        .jmp_cond   (w_dec_cond),
        .jmp_instr  (w_dec_jmp)
    );

    // An HCF opcode reaching RUN halts exactly like the external request.
    assign w_halt    = hcf || (r_state == ST_RUN && instr_type == OP_HCF);
    assign w_is_mov  = (instr_type == OP_MOV) || (instr_type == OP_MOVN);
    assign w_acc_dst = (instr_type == OP_MOV) && !dst_is_port;
    assign w_alu_acc = (instr_type == OP_ADD) || (instr_type == OP_SUB) ||
                       (instr_type == OP_NEG) || (instr_type == OP_SWP);

    always_comb begin
        w_nxt     = r_state;
        adv       = 1'b0;
        jmp_cond  = JC_INC;
        jmp_instr = 1'b0;
        acc_we    = 1'b0;
        bak_we    = 1'b0;
        if (w_halt) begin
            w_nxt = ST_HALTED;
        end else begin
            case (r_state)
                ST_HALTED: if (start) begin
                    adv      = 1'b1;
                    jmp_cond = JC_ZERO;
                    w_nxt    = ST_RUN;
                end
                ST_RUN: begin
                    jmp_instr = w_dec_jmp;
                    jmp_cond  = w_dec_cond;
                    // Port-to-port MOV enters RD_WAIT first; the write follows the read.
                    if (w_is_mov && src_is_port) begin
                        w_nxt = ST_RD_WAIT;
                    end else if (w_is_mov && dst_is_port) begin
                        w_nxt = ST_WR_WAIT;
                    end else begin
                        adv    = 1'b1;
                        acc_we = w_acc_dst || w_alu_acc;
                        bak_we = (instr_type == OP_SAV) || (instr_type == OP_SWP);
                    end
                end
                ST_RD_WAIT: if (rd_ack) begin
                    if (dst_is_port) begin
                        w_nxt = ST_WR_WAIT;
                    end else begin
                        adv    = 1'b1;
                        acc_we = w_acc_dst;
                        w_nxt  = ST_RUN;
                    end
                end
                ST_WR_WAIT: if (wr_ack) begin
                    adv   = 1'b1;
                    w_nxt = ST_RUN;
                end
                default: w_nxt = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_HALTED;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_stall  <= '0;
        end else begin
            r_state  <= w_nxt;
            r_rd_req <= (w_nxt == ST_RD_WAIT);
            r_wr_req <= (w_nxt == ST_WR_WAIT);
            if ((r_state == ST_RD_WAIT || r_state == ST_WR_WAIT) && r_stall != '1)
                r_stall <= r_stall + 1'b1;
        end
    end

    assign rd_req       = r_rd_req;
    assign wr_req       = r_wr_req;
    assign halted       = (r_state == ST_HALTED);
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_tis_node_seq.sv
// Directed bench for tis_node_seq with a 4-bit stall counter.
module tb_tis_node_seq;
    import tis_pkg::*;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset, start, hcf;
    logic [0:4]    instr_type;
    logic          src_is_port, dst_is_port, acc_zero, acc_neg, rd_ack, wr_ack;
    logic          adv, jmp_instr, rd_req, wr_req, acc_we, bak_we, halted;
    logic [0:1]    jmp_cond;
    logic [SW-1:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    tis_node_seq #(.STALL_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .hcf(hcf),
        .instr_type(instr_type), .src_is_port(src_is_port), .dst_is_port(dst_is_port),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .rd_ack(rd_ack), .wr_ack(wr_ack),
        .adv(adv), .jmp_cond(jmp_cond), .jmp_instr(jmp_instr), .rd_req(rd_req),
        .wr_req(wr_req), .acc_we(acc_we), .bak_we(bak_we), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic s, input logic d);
        instr_type  = op;
        src_is_port = s;
        dst_is_port = d;
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; hcf = 1'b0; instr_type = OP_NOP;
        src_is_port = 1'b0; dst_is_port = 1'b0; acc_zero = 1'b0; acc_neg = 1'b0;
        rd_ack = 1'b0; wr_ack = 1'b0;
        #3;
        chk("rst_halted", halted, 1); chk("rst_adv", adv, 0);
        chk("rst_rdreq", rd_req, 0); chk("rst_wrreq", wr_req, 0);
        chk("rst_stall", stall_cycles, 0); chk("rst_accwe", acc_we, 0);
        chk("rst_jc", jmp_cond, 0);
        cyc(); cyc();

        reset = 1'b1; hcf = 1'b1; start = 1'b1; #1;
        chk("hcf_over_start_adv", adv, 0);
        hcf = 1'b0; #1;
        chk("start_adv", adv, 1); chk("start_jc", jmp_cond, 2'b11); chk("start_halted", halted, 1);
        cyc(); start = 1'b0;
        chk("run_halted", halted, 0);

        set_op(OP_NOP, 0, 0);
        chk("nop_adv", adv, 1); chk("nop_jc", jmp_cond, 0); chk("nop_ji", jmp_instr, 0);
        acc_zero = 1'b1; set_op(OP_JEZ, 0, 0);
        chk("jez1_jc", jmp_cond, 2'b01); chk("jez1_adv", adv, 1); chk("jez1_ji", jmp_instr, 1);
        cyc();
        acc_zero = 1'b0; set_op(OP_JEZ, 0, 0);
        chk("jez0_jc", jmp_cond, 2'b00);
        acc_neg = 1'b1; set_op(OP_JGZ, 0, 0);
        chk("jgz_neg_jc", jmp_cond, 2'b00);
        set_op(OP_JLZ, 0, 0);
        chk("jlz_neg_jc", jmp_cond, 2'b01);
        acc_neg = 1'b0; set_op(OP_JGZ, 0, 0);
        chk("jgz_pos_jc", jmp_cond, 2'b01);
        set_op(OP_JNZ, 0, 0);
        chk("jnz_pos_jc", jmp_cond, 2'b01);
        set_op(OP_JRO, 0, 0);
        chk("jro_jc", jmp_cond, 2'b10); chk("jro_ji", jmp_instr, 1);
        set_op(OP_ADD, 0, 0);
        chk("add_accwe", acc_we, 1); chk("add_bakwe", bak_we, 0); chk("add_ji", jmp_instr, 0);
        set_op(OP_SWP, 0, 0);
        chk("swp_accwe", acc_we, 1); chk("swp_bakwe", bak_we, 1);
        set_op(OP_SAV, 0, 0);
        chk("sav_accwe", acc_we, 0); chk("sav_bakwe", bak_we, 1);
        cyc();

        // MOV UP,ACC: ack in cycle 4
        set_op(OP_MOV, 1, 0);
        chk("mrd_c0_adv", adv, 0); chk("mrd_c0_accwe", acc_we, 0);
        cyc();
        chk("mrd_c1_rdreq", rd_req, 1); chk("mrd_c1_adv", adv, 0);
        cyc(); cyc();
        chk("mrd_c3_rdreq", rd_req, 1); chk("mrd_c3_stall", stall_cycles, 2);
        cyc(); rd_ack = 1'b1; #1;
        chk("mrd_c4_adv", adv, 1); chk("mrd_c4_accwe", acc_we, 1); chk("mrd_c4_rdreq", rd_req, 1);
        cyc(); rd_ack = 1'b0; set_op(OP_NOP, 0, 0);
        chk("mrd_done_rdreq", rd_req, 0); chk("mrd_done_stall", stall_cycles, 4);
        chk("mrd_done_adv", adv, 1);
        cyc();

        // MOV LEFT,RIGHT: rd_ack cycle 2, wr_ack cycle 5
        set_op(OP_MOV, 1, 1);
        chk("mpp_c0_adv", adv, 0);
        cyc(); wr_ack = 1'b1; #1;
        chk("mpp_c1_wrack_ign", adv, 0); chk("mpp_c1_rdreq", rd_req, 1);
        cyc(); wr_ack = 1'b0; rd_ack = 1'b1; #1;
        chk("mpp_c2_adv", adv, 0); chk("mpp_c2_accwe", acc_we, 0);
        cyc(); rd_ack = 1'b0; #1;
        chk("mpp_c3_rdreq", rd_req, 0); chk("mpp_c3_wrreq", wr_req, 1); chk("mpp_c3_adv", adv, 0);
        cyc(); rd_ack = 1'b1; #1;
        chk("mpp_c4_rdack_ign", adv, 0);
        cyc(); rd_ack = 1'b0; wr_ack = 1'b1; #1;
        chk("mpp_c5_adv", adv, 1); chk("mpp_c5_accwe", acc_we, 0);
        cyc(); wr_ack = 1'b0; set_op(OP_NOP, 0, 0);
        chk("mpp_done_wrreq", wr_req, 0); chk("mpp_done_stall", stall_cycles, 9);
        cyc();

        // MOV ACC,DOWN then hcf in WR_WAIT
        set_op(OP_MOV, 0, 1);
        chk("mwr_c0_adv", adv, 0);
        cyc();
        chk("mwr_c1_wrreq", wr_req, 1);
        cyc(); hcf = 1'b1; #1;
        chk("hcf_adv", adv, 0);
        cyc(); hcf = 1'b0; #1;
        chk("hcf_halted", halted, 1); chk("hcf_wrreq", wr_req, 0); chk("hcf_stall", stall_cycles, 11);
        wr_ack = 1'b1; #1;
        chk("hcf_late_ack_adv", adv, 0);
        cyc(); wr_ack = 1'b0; #1;
        chk("hcf_late_halted", halted, 1); chk("hcf_late_wrreq", wr_req, 0);

        // restart, then rd_ack in RUN is ignored
        start = 1'b1; #1;
        chk("rs_adv", adv, 1); chk("rs_jc", jmp_cond, 2'b11);
        cyc(); set_op(OP_NOP, 0, 0); rd_ack = 1'b1; #1;
        chk("rs_run", halted, 0); chk("run_rdack_accwe", acc_we, 0);
        start = 1'b1; #1;
        chk("start_in_run_jc", jmp_cond, 2'b00);
        cyc(); start = 1'b0; rd_ack = 1'b0; #1;
        chk("run_rdack_rdreq", rd_req, 0);

        // hold RD_WAIT for 2^SW+3 cycles
        set_op(OP_MOV, 1, 0);
        for (int i = 0; i < (1 << SW) + 3; i++) cyc();
        chk("sat_stall", stall_cycles, 15); chk("sat_rdreq", rd_req, 1);
        cyc();
        chk("sat_stall_hold", stall_cycles, 15);
        reset = 1'b0; #1;
        chk("midrst_halted", halted, 1); chk("midrst_rdreq", rd_req, 0);
        chk("midrst_stall", stall_cycles, 0);
        cyc(); reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tis_node_seq.md
Name: tis_node_seq

Overview:
- Per-node instruction sequencer for the TIS-100 execution node.
- Decodes the current instruction class and the ACC flags, and drives the jump-path next-address select and the IP advance enable.
- Runs the blocking port handshakes for MOV to and from neighbour ports, stalling the IP until each transfer completes.
- Handles halt and restart, where restart reloads IP to 0.

Parameters:
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  node clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave HALTED and restart the program from address 0.
- hcf  in  1  halt request, sampled every cycle.
- instr_type  in  [0:4]  opcode of the current instruction.
- src_is_port  in  1  source operand is a neighbour port.
- dst_is_port  in  1  destination operand is a neighbour port.
- acc_zero  in  1  ACC == 0.
- acc_neg  in  1  ACC < 0.
- rd_ack  in  1  neighbour presents read data this cycle.
- wr_ack  in  1  neighbour accepted write data this cycle.
- adv  out  1  IP register loads the selected next address.
- jmp_cond  out  [0:1]  next-address select:
  - 00 = IP+1
  - 01 = label address
  - 10 = JRO target
  - 11 = zero
- jmp_instr  out  1  current instruction is a jump class.
- rd_req  out  1  port read pending.
- wr_req  out  1  port write pending.
- acc_we  out  1  ACC write strobe.
- bak_we  out  1  BAK write strobe.
- halted  out  1  sequencer is in HALTED.
- stall_cycles  out  [STALL_W-1:0]  saturating count of port-wait cycles.

Behaviour:
- States: HALTED, RUN, RD_WAIT, WR_WAIT.
- Reset (asynchronous, active-low) puts the block in HALTED.
  - All outputs are 0, except halted=1.
  - stall_cycles is 0.
- HALTED:
  - start=1 gives adv=1 and jmp_cond=11 for one cycle, then the state goes to RUN.
  - start=0 gives adv=0.
- RUN, non-port instruction:
  - Completes in 1 cycle with adv=1.
  - Strobes are combinational on the opcode:
    - ACC-writing ops (MOV to ACC, ADD, SUB, NEG, SWP) assert acc_we.
    - SAV and SWP assert bak_we.
- Jump decode, applied in RUN only:
  - jmp_instr=1 for JMP, JEZ, JNZ, JGZ, JLZ, JRO.
  - JMP gives 01.
  - JEZ gives 01 if acc_zero, else 00.
  - JNZ gives 01 if !acc_zero, else 00.
  - JGZ gives 01 if !acc_zero&&!acc_neg, else 00.
  - JLZ gives 01 if acc_neg, else 00.
  - JRO gives 10.
  - All other opcodes give 00.
- Read stall:
  - A MOV with src_is_port=1 in RUN goes to RD_WAIT.
  - RD_WAIT holds rd_req=1 and adv=0.
  - When rd_ack=1 is sampled:
    - If the destination is ACC: acc_we=1 that cycle, adv=1, next state RUN.
    - If dst_is_port=1: next state WR_WAIT, adv=0.
    - Otherwise (e.g. NIL): adv=1, next state RUN.
- Write stall:
  - A MOV with dst_is_port=1 (and a non-port source) in RUN goes to WR_WAIT.
  - WR_WAIT holds wr_req=1 and adv=0.
  - When wr_ack=1 is sampled: adv=1, next state RUN.
- Request timing:
  - rd_req and wr_req are registered.
  - Each deasserts in the cycle after its ack.
- Wait ordering: a port-to-port MOV always completes the read before the write.
- Acks in the wrong state: rd_ack in WR_WAIT or RUN is ignored, and so is wr_ack in RD_WAIT or RUN.
- hcf:
  - Checked in any state, with priority over all other transitions.
  - Next state is HALTED, adv=0, and both reqs drop next cycle.
  - A pending transfer is abandoned.
- start in a non-HALTED state is ignored.
- stall_cycles:
  - +1 each cycle in RD_WAIT or WR_WAIT.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset mid-wait: returns immediately to HALTED with reqs low.
- adv=1 and a stall never coexist.

Decomposition:
- Shared package tis_pkg holds:
  - opcode constants (5-bit: NOP, MOV, SWP, SAV, ADD, SUB, NEG, JMP, JEZ, JNZ, JGZ, JLZ, JRO, HCF);
  - the jmp_cond encodings (JC_INC, JC_LABEL, JC_REL, JC_ZERO);
  - the state encoding.
- One sub-module, tis_jmp_decode: combinational opcode plus flags to jmp_cond and jmp_instr.

Test Plan:
- Reset low, then high with start=1 for 1 cycle -> halted 1→0, adv=1 with jmp_cond=11 in that cycle, then RUN.
- JEZ with acc_zero=1 -> jmp_cond=01, adv=1. JEZ with acc_zero=0 -> 00. JGZ with acc_neg=1 -> 00. JRO -> 10 with jmp_instr=1.
- MOV UP,ACC with rd_ack at cycle 4 -> rd_req high for cycles 1-4, adv=0 until cycle 4, acc_we=1 in cycle 4, stall_cycles=4.
- MOV LEFT,RIGHT with rd_ack at cycle 2 and wr_ack at cycle 5 -> rd_req then wr_req, single adv in cycle 5, no acc_we.
- hcf during WR_WAIT -> next cycle halted=1 and wr_req=0; a later wr_ack has no effect.
- Hold RD_WAIT for 2^STALL_W+3 cycles (use STALL_W=4) -> stall_cycles sticks at 15.
